comp_dispatch_scheduler: RTL and testbench

COMP_DISPATCH_SCHEDULER -- requirements
Module: comp_dispatch_scheduler

---
 rtl/comp_dispatch_scheduler_pkg.sv | 29 ++
 rtl/comp_dispatch_scheduler_sched_order_fifo.sv | 77 +++++++
 rtl/comp_dispatch_scheduler.sv | 249 ++++++++++++++++++++++++
 tb/tb_comp_dispatch_scheduler.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/comp_dispatch_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// Package     : comp_dispatch_scheduler_pkg
// Description : Shared types for the compression dispatch scheduler: core
//               index, per-core outstanding count and the FSM state enums.
// Revision    : 1.0 - initial release
// ============================================================================
package comp_dispatch_scheduler_pkg;

    // Core index is sized for the largest supported core count (16)
    localparam int c_core_idx_w = $clog2(16);
    // Outstanding count covers the largest supported in-flight limit (7)
    localparam int c_out_cnt_w  = 3;

    typedef logic [c_core_idx_w-1:0] core_idx_t;
    typedef logic [c_out_cnt_w-1:0]  out_cnt_t;

    typedef enum logic [0:0] {
        IN_IDLE   = 1'b0,
        IN_STREAM = 1'b1
    } in_state_t;

    typedef enum logic [0:0] {
        OUT_IDLE   = 1'b0,
        OUT_STREAM = 1'b1
    } out_state_t;

endpackage
`default_nettype wire

// File: rtl/comp_dispatch_scheduler_sched_order_fifo.sv
`default_nettype none
// ============================================================================
// Module      : sched_order_fifo
// Description : Synchronous FIFO of core indices recording the order in which
//               packets were dispatched. Registered full/empty flags and
//               simultaneous push/pop.
// Revision    : 1.0 - initial release
// ============================================================================
module sched_order_fifo
    import comp_dispatch_scheduler_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      push,
    input  core_idx_t din,
    input  logic      pop,
    output core_idx_t dout,
    output logic      full,
    output logic      empty
);
    localparam int c_addr_w = $clog2(DEPTH);
    localparam logic [c_addr_w:0] c_last = (c_addr_w+1)'(DEPTH - 1);
    localparam logic [c_addr_w:0] c_one  = (c_addr_w+1)'(1);

    core_idx_t           r_mem [DEPTH];
    logic [c_addr_w-1:0] r_wr_ptr;
    logic [c_addr_w-1:0] r_rd_ptr;
    logic [c_addr_w:0]   r_count;
    logic                r_full;
    logic                r_empty;
    logic                w_do_push;
    logic                w_do_pop;

    assign w_do_push = push && !r_full;
    assign w_do_pop  = pop && !r_empty;
    assign dout      = r_mem[r_rd_ptr];
    assign full      = r_full;
    assign empty     = r_empty;

    // Storage array, written only on an accepted push
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    // Pointers, occupancy and registered status flags
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_do_push && !w_do_pop) begin
                r_count <= r_count + c_one;
                r_full  <= (r_count == c_last);
                r_empty <= 1'b0;
            end else if (!w_do_push && w_do_pop) begin
                r_count <= r_count - c_one;
                r_full  <= 1'b0;
                r_empty <= (r_count == c_one);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/comp_dispatch_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : comp_dispatch_scheduler
// Description : Dispatches host packets round-robin to N_CORES compression
//               cores (bounded in-flight per core) and re-merges the core
//               outputs in the original packet order.
// Options     : COMP_SCHED_STATS_EN adds pkt_cnt / stall_cnt statistics ports.
// Revision    : 1.0 - initial release
// ============================================================================
module comp_dispatch_scheduler
    import comp_dispatch_scheduler_pkg::*;
#(
    parameter int N_CORES         = 4,
    parameter int MAX_OUTSTANDING = 2,
    parameter int ORDER_DEPTH     = 16,
    parameter int DATA_BITS       = 512
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [DATA_BITS-1:0]           s_tdata,
    input  logic [DATA_BITS/8-1:0]         s_tkeep,
    input  logic                           s_tlast,
    input  logic                           s_tvalid,
    output logic                           s_tready,
    output logic [DATA_BITS-1:0]           core_in_tdata,
    output logic [DATA_BITS/8-1:0]         core_in_tkeep,
    output logic                           core_in_tlast,
    output logic [N_CORES-1:0]             core_in_tvalid,
    input  logic [N_CORES-1:0]             core_in_tready,
    input  logic [N_CORES*DATA_BITS-1:0]   core_out_tdata,
    input  logic [N_CORES*DATA_BITS/8-1:0] core_out_tkeep,
    input  logic [N_CORES-1:0]             core_out_tlast,
    input  logic [N_CORES-1:0]             core_out_tvalid,
    output logic [N_CORES-1:0]             core_out_tready,
    output logic [DATA_BITS-1:0]           m_tdata,
    output logic [DATA_BITS/8-1:0]         m_tkeep,
    output logic                           m_tlast,
    output logic                           m_tvalid,
    input  logic                           m_tready
`ifdef COMP_SCHED_STATS_EN
    ,
    output logic [N_CORES*32-1:0]          pkt_cnt,
    output logic [31:0]                    stall_cnt
`endif
);
    localparam int       c_keep_bits = DATA_BITS / 8;
    localparam out_cnt_t c_out_max   = out_cnt_t'(MAX_OUTSTANDING);
    localparam out_cnt_t c_cnt_one   = out_cnt_t'(1);

    in_state_t    r_in_state;
    in_state_t    w_in_next;
    out_state_t   r_out_state;
    out_state_t   w_out_next;
    core_idx_t    r_in_sel;
    core_idx_t    r_out_sel;
    core_idx_t    r_last_grant;
    out_cnt_t     r_outstanding [N_CORES];
    logic [N_CORES-1:0] w_elig;
    logic [N_CORES-1:0] w_inc;
    logic [N_CORES-1:0] w_dec;
    core_idx_t    w_grant_idx;
    logic         w_found;
    logic         w_grant;
    logic         w_pop;
    logic         w_out_done;
    core_idx_t    w_fifo_dout;
    logic         w_fifo_full;
    logic         w_fifo_empty;

    // Input beats are broadcast; only the selected core sees tvalid
    assign core_in_tdata = s_tdata;
    assign core_in_tkeep = s_tkeep;
    assign core_in_tlast = s_tlast;

    // Per-core eligibility and counter update strobes
    always_comb begin
        w_elig = '0;
        w_inc  = '0;
        w_dec  = '0;
        for (int i = 0; i < N_CORES; i++) begin
            w_elig[i] = (r_outstanding[i] < c_out_max);
            w_inc[i]  = w_grant && (w_grant_idx == core_idx_t'(i));
            w_dec[i]  = w_out_done && (r_out_sel == core_idx_t'(i));
        end
    end

    // Round-robin search: smallest distance from last_grant+1 wins
    always_comb begin : p_rr_search
        int v_dist;
        int v_best;
        v_dist      = 0;
        v_best      = N_CORES;
        w_found     = 1'b0;
        w_grant_idx = '0;
        for (int i = 0; i < N_CORES; i++) begin
            v_dist = i - int'(r_last_grant) - 1;
            if (v_dist < 0) begin
                v_dist = v_dist + N_CORES;
            end
            if (w_elig[i] && (v_dist < v_best)) begin
                v_best      = v_dist;
                w_grant_idx = core_idx_t'(i);
                w_found     = 1'b1;
            end
        end
    end

    // Input FSM next state and input-side handshakes
    always_comb begin
        w_in_next      = r_in_state;
        w_grant        = 1'b0;
        s_tready       = 1'b0;
        core_in_tvalid = '0;
        case (r_in_state)
            IN_IDLE: begin
                if (s_tvalid && !w_fifo_full && w_found) begin
                    w_grant   = 1'b1;
                    w_in_next = IN_STREAM;
                end
            end
            IN_STREAM: begin
                for (int i = 0; i < N_CORES; i++) begin
                    if (r_in_sel == core_idx_t'(i)) begin
                        s_tready          = core_in_tready[i];
                        core_in_tvalid[i] = s_tvalid;
                    end
                end
                if (s_tvalid && s_tready && s_tlast) begin
                    w_in_next = IN_IDLE;
                end
            end
            default: w_in_next = IN_IDLE;
        endcase
    end

    // Output FSM next state and output mux from the selected core
    always_comb begin
        w_out_next      = r_out_state;
        w_pop           = 1'b0;
        w_out_done      = 1'b0;
        m_tdata         = '0;
        m_tkeep         = '0;
        m_tlast         = 1'b0;
        m_tvalid        = 1'b0;
        core_out_tready = '0;
        case (r_out_state)
            OUT_IDLE: begin
                if (!w_fifo_empty) begin
                    w_pop      = 1'b1;
                    w_out_next = OUT_STREAM;
                end
            end
            OUT_STREAM: begin
                for (int i = 0; i < N_CORES; i++) begin
                    if (r_out_sel == core_idx_t'(i)) begin
                        m_tdata            = core_out_tdata[i*DATA_BITS +: DATA_BITS];
                        m_tkeep            = core_out_tkeep[i*c_keep_bits +: c_keep_bits];
                        m_tlast            = core_out_tlast[i];
                        m_tvalid           = core_out_tvalid[i];
                        core_out_tready[i] = m_tready;
                    end
                end
                if (m_tvalid && m_tready && m_tlast) begin
                    w_out_done = 1'b1;
                    w_out_next = OUT_IDLE;
                end
            end
            default: w_out_next = OUT_IDLE;
        endcase
    end

    // State registers and grant / pop bookkeeping
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_in_state   <= IN_IDLE;
            r_out_state  <= OUT_IDLE;
            r_in_sel     <= '0;
            r_out_sel    <= '0;
            r_last_grant <= core_idx_t'(N_CORES - 1);
        end else begin
            r_in_state  <= w_in_next;
            r_out_state <= w_out_next;
            if (w_grant) begin
                r_in_sel     <= w_grant_idx;
                r_last_grant <= w_grant_idx;
            end
            if (w_pop) begin
                r_out_sel <= w_fifo_dout;
            end
        end
    end

    // Saturating in-flight counters; simultaneous inc/dec cancel out
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < N_CORES; i++) begin
                r_outstanding[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_CORES; i++) begin
                if (w_inc[i] && !w_dec[i] && (r_outstanding[i] != c_out_max)) begin
                    r_outstanding[i] <= r_outstanding[i] + c_cnt_one;
                end else if (w_dec[i] && !w_inc[i] && (r_outstanding[i] != '0)) begin
                    r_outstanding[i] <= r_outstanding[i] - c_cnt_one;
                end
            end
        end
    end

    sched_order_fifo #(
        .DEPTH (ORDER_DEPTH)
    ) u_order_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (w_grant),
        .din   (w_grant_idx),
        .pop   (w_pop),
        .dout  (w_fifo_dout),
        .full  (w_fifo_full),
        .empty (w_fifo_empty)
    );

`ifdef COMP_SCHED_STATS_EN
    logic [N_CORES*32-1:0] r_pkt_cnt;
    logic [31:0]           r_stall_cnt;

    assign pkt_cnt   = r_pkt_cnt;
    assign stall_cnt = r_stall_cnt;

    // Wrapping per-core grant counters and idle-stall counter
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pkt_cnt   <= '0;
            r_stall_cnt <= '0;
        end else begin
            for (int i = 0; i < N_CORES; i++) begin
                if (w_inc[i]) begin
                    r_pkt_cnt[i*32 +: 32] <= r_pkt_cnt[i*32 +: 32] + 32'd1;
                end
            end
            if ((r_in_state == IN_IDLE) && s_tvalid && !w_grant) begin
                r_stall_cnt <= r_stall_cnt + 32'd1;
            end
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_comp_dispatch_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_comp_dispatch_scheduler
// Description : Scoreboard bench for comp_dispatch_scheduler with 4 simple
//               core models (output = input XOR per-core key). Build with
//               COMP_SCHED_STATS_EN to also exercise the statistics ports.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_comp_dispatch_scheduler;
    localparam int NC = 4;
    localparam int DW = 32;
    localparam int KW = DW / 8;

    typedef struct packed {
        logic [DW-1:0] d;
        logic [KW-1:0] k;
        logic          l;
    } beat_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst_n;
    logic [DW-1:0]    s_tdata;
    logic [KW-1:0]    s_tkeep;
    logic             s_tlast, s_tvalid, s_tready;
    logic [DW-1:0]    core_in_tdata;
    logic [KW-1:0]    core_in_tkeep;
    logic             core_in_tlast;
    logic [NC-1:0]    core_in_tvalid, core_in_tready;
    logic [NC*DW-1:0] core_out_tdata;
    logic [NC*KW-1:0] core_out_tkeep;
    logic [NC-1:0]    core_out_tlast, core_out_tvalid, core_out_tready;
    logic [DW-1:0]    m_tdata;
    logic [KW-1:0]    m_tkeep;
    logic             m_tlast, m_tvalid, m_tready;
`ifdef COMP_SCHED_STATS_EN
    logic [NC*32-1:0] pkt_cnt;
    logic [31:0]      stall_cnt;
`endif

    comp_dispatch_scheduler #(
        .N_CORES(NC), .MAX_OUTSTANDING(2), .ORDER_DEPTH(16), .DATA_BITS(DW)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .s_tdata(s_tdata), .s_tkeep(s_tkeep), .s_tlast(s_tlast),
        .s_tvalid(s_tvalid), .s_tready(s_tready),
        .core_in_tdata(core_in_tdata), .core_in_tkeep(core_in_tkeep),
        .core_in_tlast(core_in_tlast), .core_in_tvalid(core_in_tvalid),
        .core_in_tready(core_in_tready),
        .core_out_tdata(core_out_tdata), .core_out_tkeep(core_out_tkeep),
        .core_out_tlast(core_out_tlast), .core_out_tvalid(core_out_tvalid),
        .core_out_tready(core_out_tready),
        .m_tdata(m_tdata), .m_tkeep(m_tkeep), .m_tlast(m_tlast),
        .m_tvalid(m_tvalid), .m_tready(m_tready)
`ifdef COMP_SCHED_STATS_EN
        , .pkt_cnt(pkt_cnt), .stall_cnt(stall_cnt)
`endif
    );

    int    n_checks;
    int    n_fail;
    beat_t exp_q[$];
    beat_t mon_e;

    function automatic logic [DW-1:0] key(input int c);
        return DW'(32'h1111_1111 * (c + 1));
    endfunction

    task automatic check(input string name, input bit ok,
                         input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    // ---------------- core models: FIFO per core, data XOR key -------------
    beat_t         cmem [NC][64];
    logic [5:0]    cwp [NC];
    logic [5:0]    crp [NC];
    logic [NC-1:0] out_en;
    logic [NC-1:0] in_rdy;

    assign core_in_tready = in_rdy;

    always @(posedge clk) begin
        for (int i = 0; i < NC; i++) begin
            if (!rst_n) begin
                cwp[i] <= '0;
                crp[i] <= '0;
            end else begin
                if (core_in_tvalid[i] && core_in_tready[i]) begin
                    cmem[i][cwp[i]].d <= core_in_tdata ^ key(i);
                    cmem[i][cwp[i]].k <= core_in_tkeep;
                    cmem[i][cwp[i]].l <= core_in_tlast;
                    cwp[i] <= cwp[i] + 6'd1;
                end
                if (core_out_tvalid[i] && core_out_tready[i]) begin
                    crp[i] <= crp[i] + 6'd1;
                end
            end
        end
    end

    always_comb begin
        core_out_tvalid = '0;
        core_out_tdata  = '0;
        core_out_tkeep  = '0;
        core_out_tlast  = '0;
        for (int i = 0; i < NC; i++) begin
            core_out_tvalid[i]        = out_en[i] && (cwp[i] != crp[i]);
            core_out_tdata[i*DW +: DW] = cmem[i][crp[i]].d;
            core_out_tkeep[i*KW +: KW] = cmem[i][crp[i]].k;
            core_out_tlast[i]         = cmem[i][crp[i]].l;
        end
    end

    // ---------------- monitor: pop and compare each output beat ------------
    always @(negedge clk) begin
        if (rst_n && m_tvalid && m_tready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_beat", 1'b0, 64'(m_tdata), 64'd0);
            end else begin
                mon_e = exp_q.pop_front();
                check("out_beat", (m_tdata == mon_e.d) && (m_tkeep == mon_e.k) &&
                      (m_tlast == mon_e.l), {27'd0, m_tdata, m_tkeep, m_tlast},
                      {27'd0, mon_e.d, mon_e.k, mon_e.l});
            end
        end
    end

    // ---------------- stimulus helpers --------------------------------------
    task automatic send_pkt(input int core, input int nb, input logic [DW-1:0] base);
        int    waitc;
        beat_t e;
        for (int b = 0; b < nb; b++) begin
            s_tdata  = base + DW'(b);
            s_tkeep  = (b == nb - 1) ? 4'h3 : 4'hF;
            s_tlast  = (b == nb - 1);
            s_tvalid = 1'b1;
            waitc    = 0;
            forever begin
                @(negedge clk);
                if (b == 0 && waitc == 0) check("bubble", s_tready == 1'b0, 64'(s_tready), 64'd0);
                if (s_tready) break;
                waitc++;
                if (waitc > 300) begin
                    check("s_tready_timeout", 1'b0, 64'(waitc), 64'd300);
                    break;
                end
            end
            if (b == 0) check("grant", core_in_tvalid == NC'(1 << core),
                              64'(core_in_tvalid), 64'(1 << core));
            e.d = s_tdata ^ key(core);
            e.k = s_tkeep;
            e.l = s_tlast;
            exp_q.push_back(e);
            @(posedge clk); #1;
        end
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
    endtask

    task automatic wait_drain();
        int c;
        c = 0;
        while (exp_q.size() != 0 && c < 2000) begin
            @(negedge clk);
            c++;
        end
        check("drain", exp_q.size() == 0, 64'(exp_q.size()), 64'd0);
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        rst_n    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n    = 1'b1;
        m_tready = 1'b1;
        out_en   = '1;
        exp_q.delete();
    endtask

    task automatic check_quiet(input string tag);
        int sum;
        sum = 0;
        for (int i = 0; i < NC; i++) sum += int'(dut.r_outstanding[i]);
        check({tag, "_s_tready"}, s_tready == 1'b0, 64'(s_tready), 64'd0);
        check({tag, "_core_in_tvalid"}, core_in_tvalid == '0, 64'(core_in_tvalid), 64'd0);
        check({tag, "_core_out_tready"}, core_out_tready == '0, 64'(core_out_tready), 64'd0);
        check({tag, "_m_tvalid"}, m_tvalid == 1'b0, 64'(m_tvalid), 64'd0);
        check({tag, "_outstanding"}, sum == 0, 64'(sum), 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence -------------------------------------
    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        s_tvalid = 1'b0;
        s_tdata  = '0;
        s_tkeep  = '0;
        s_tlast  = 1'b0;
        m_tready = 1'b1;
        out_en   = '1;
        in_rdy   = '1;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_quiet("reset");
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Single 3-beat packet goes to core 0 and drains
        send_pkt(0, 3, 32'h1000_0000);
        wait_drain();
        check("single_outstanding0", dut.r_outstanding[0] == '0,
              64'(dut.r_outstanding[0]), 64'd0);

        // Back-to-back packets: round-robin 0,1,2,3,0 in order
        do_reset();
        send_pkt(0, 1, 32'h2000_0000);
        send_pkt(1, 2, 32'h2000_0100);
        send_pkt(2, 3, 32'h2000_0200);
        send_pkt(3, 1, 32'h2000_0300);
        send_pkt(0, 2, 32'h2000_0400);
        wait_drain();

        // Output blocked: 8 packets fill all cores, 9th stalls until a drain
        do_reset();
        m_tready = 1'b0;
        for (int k = 0; k < 8; k++) send_pkt(k % NC, 1, 32'h3000_0000 + DW'(k));
        fork
            send_pkt(0, 1, 32'h3000_0008);
            begin
                repeat (6) begin
                    @(negedge clk);
                    check("stall_s_tready", s_tready == 1'b0, 64'(s_tready), 64'd0);
                end
                @(posedge clk); #1;
                m_tready = 1'b1;
            end
        join
        wait_drain();

        // Core 1 late: core 2 output held back until core 1 completes
        do_reset();
        out_en[1] = 1'b0;
        send_pkt(0, 1, 32'h4000_0000);
        send_pkt(1, 2, 32'h4000_0100);
        send_pkt(2, 1, 32'h4000_0200);
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("hold_core2_valid", core_out_tvalid[2] == 1'b1, 64'(core_out_tvalid), 64'h4);
        check("hold_core2_ready", core_out_tready[2] == 1'b0, 64'(core_out_tready), 64'd0);
        check("hold_m_tvalid", m_tvalid == 1'b0, 64'(m_tvalid), 64'd0);
        check("hold_pending", exp_q.size() == 3, 64'(exp_q.size()), 64'd3);
        @(posedge clk); #1;
        out_en[1] = 1'b1;
        wait_drain();

        // Reset asserted while beat 2 of a packet is presented
        do_reset();
        m_tready = 1'b0;
        s_tdata  = 32'h5000_0000;
        s_tkeep  = 4'hF;
        s_tlast  = 1'b0;
        s_tvalid = 1'b1;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (s_tready) break;
        end
        @(posedge clk); #1;
        s_tdata = 32'h5000_0001;
        rst_n   = 1'b0;
        @(posedge clk); #1;
        rst_n    = 1'b1;
        s_tvalid = 1'b0;
        exp_q.delete();
        @(negedge clk);
        check_quiet("midpkt_reset");
        @(posedge clk); #1;
        m_tready = 1'b1;
        send_pkt(0, 2, 32'h5000_0100);
        wait_drain();

`ifdef COMP_SCHED_STATS_EN
        // Statistics: 8 grants then exactly 4 stalled cycles
        do_reset();
        m_tready = 1'b0;
        for (int k = 0; k < 8; k++) send_pkt(k % NC, 1, 32'h6000_0000 + DW'(k));
        s_tdata  = 32'h6000_00FF;
        s_tlast  = 1'b1;
        s_tvalid = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        @(negedge clk);
        check("stall_cnt", stall_cnt == 32'd4, 64'(stall_cnt), 64'd4);
        for (int i = 0; i < NC; i++)
            check("pkt_cnt", pkt_cnt[i*32 +: 32] == 32'd2, 64'(pkt_cnt[i*32 +: 32]), 64'd2);
        @(posedge clk); #1;
        m_tready = 1'b1;
        wait_drain();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
